fetch_sequencer: RTL and testbench

- Owns the architectural PC register and sequences instruction fetch for the pipeline IF stage.
- Picks the next fetch address: sequential PC+4, or a redirect target supplied by the ID-stage next-PC logic on taken branch/jump/jr.
- Runs a req/gnt/rvalid handshake with instruction memory and presents fetched instructions to the IF/ID register through a stall-aware output buffer.
- Discards in-flight fetches made stale by a redirect.

---
 rtl/fetch_sequencer.sv | 122 ++++++++++++
 tb/tb_fetch_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: owns pc_r, runs the imem req/gnt/rvalid handshake, buffers one instr.
// Optional misaligned-redirect fault enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
`endif
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        exc_o
);

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    WAIT
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc_r, pc_nx;
  logic [31:0] fetch_pc, fetch_pc_nx;
  logic        kill, kill_nx;
  logic        load;
  logic        grant;
  logic [31:0] tgt;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault;
  logic exc_r;

  assign fault = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign tgt   = fault ? EXC_VECTOR : redirect_pc_i;
  assign exc_o = exc_r;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) exc_r <= 1'b0;
    else       exc_r <= fault;
  end
`else
  assign tgt   = redirect_pc_i;
  assign exc_o = 1'b0;
`endif

  // No new request while a held instruction is waiting on a stall.
  assign imem_req_o  = (state == REQ) && !(if_valid_o && stall_i);
  assign imem_addr_o = pc_r;
  assign grant       = imem_req_o && imem_gnt_i;

  always_comb begin
    state_nx    = state;
    pc_nx       = pc_r;
    fetch_pc_nx = fetch_pc;
    kill_nx     = kill;
    load        = 1'b0;
    unique case (state)
      BOOT: state_nx = REQ;
      REQ: begin
        if (grant) begin
          state_nx    = WAIT;
          fetch_pc_nx = pc_r;
          kill_nx     = redirect_i;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          state_nx = REQ;
          kill_nx  = 1'b0;
          load     = !kill && !redirect_i;
        end else if (redirect_i) begin
          kill_nx = 1'b1;
        end
      end
      default: state_nx = BOOT;
    endcase
    if (redirect_i) pc_nx = tgt;
    else if (grant) pc_nx = pc_r + 32'd4;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= BOOT;
      pc_r     <= RESET_PC;
      fetch_pc <= '0;
      kill     <= 1'b0;
    end else begin
      state    <= state_nx;
      pc_r     <= pc_nx;
      fetch_pc <= fetch_pc_nx;
      kill     <= kill_nx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if_valid_o <= 1'b0;
      if_pc_o    <= '0;
      if_instr_o <= '0;
    end else if (redirect_i) begin
      if_valid_o <= 1'b0;
    end else if (load) begin
      if_valid_o <= 1'b1;
      if_pc_o    <= fetch_pc;
      if_instr_o <= imem_rdata_i;
    end else if (if_valid_o && !stall_i) begin
      if_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector bench for fetch_sequencer; memory responses are scripted per cycle.
// Honors FETCH_ALIGN_CHECK_EN for the misaligned-redirect expectations.
module tb_fetch_sequencer;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic ALN = 1'b1;
  localparam logic [31:0] MIS = 32'h0000_4180;
`else
  localparam logic ALN = 1'b0;
  localparam logic [31:0] MIS = 32'h0000_3102;
`endif

  logic        clk;
  logic        rstn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        valid;
  logic [31:0] ipc;
  logic [31:0] instr;
  logic        exc;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_sequencer dut (
    .clk           (clk),
    .rstn          (rstn),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .if_valid_o    (valid),
    .if_pc_o       (ipc),
    .if_instr_o    (instr),
    .exc_o         (exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] ipc;
    logic [31:0] ins;
    logic        exc;
  } vec_t;

  vec_t tv[31];

  function automatic vec_t mk(
    logic st, logic rd, logic [31:0] rpc,
    logic g, logic rv, logic [31:0] rdt,
    logic rq, logic [31:0] a, logic v,
    logic [31:0] p, logic [31:0] ins, logic e
  );
    vec_t t;
    t.st = st; t.rd = rd; t.rpc = rpc;
    t.gnt = g; t.rv = rv; t.rdata = rdt;
    t.req = rq; t.addr = a; t.v = v;
    t.ipc = p; t.ins = ins; t.exc = e;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(logic st, logic rd, logic [31:0] rpc,
                       logic g, logic rv, logic [31:0] rdt);
    stall = st; redirect = rd; redirect_pc = rpc;
    gnt = g; rvalid = rv; rdata = rdt;
  endtask

  initial begin
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    tv[0]  = mk(0,0,0,           0,0,0,            0,32'h3000,0,0,0,0);
    tv[1]  = mk(0,0,0,           1,0,0,            1,32'h3000,0,0,0,0);
    tv[2]  = mk(0,0,0,           0,1,32'hAAAA3000, 0,32'h3004,0,0,0,0);
    tv[3]  = mk(0,0,0,           1,0,0,            1,32'h3004,1,32'h3000,32'hAAAA3000,0);
    tv[4]  = mk(0,0,0,           0,1,32'hAAAA3004, 0,32'h3008,0,0,0,0);
    tv[5]  = mk(1,0,0,           1,0,0,            0,32'h3008,1,32'h3004,32'hAAAA3004,0);
    tv[6]  = mk(1,0,0,           1,0,0,            0,32'h3008,1,32'h3004,32'hAAAA3004,0);
    tv[7]  = mk(1,0,0,           1,0,0,            0,32'h3008,1,32'h3004,32'hAAAA3004,0);
    tv[8]  = mk(0,0,0,           1,0,0,            1,32'h3008,1,32'h3004,32'hAAAA3004,0);
    tv[9]  = mk(0,1,32'h3100,    0,1,32'hDEAD0002, 0,32'h300C,0,0,0,0);
    tv[10] = mk(0,0,0,           1,0,0,            1,32'h3100,0,0,0,0);
    tv[11] = mk(0,0,0,           0,1,32'hAAAA3100, 0,32'h3104,0,0,0,0);
    tv[12] = mk(0,0,0,           1,0,0,            1,32'h3104,1,32'h3100,32'hAAAA3100,0);
    tv[13] = mk(0,0,0,           0,1,32'hAAAA3104, 0,32'h3108,0,0,0,0);
    tv[14] = mk(1,1,32'h3200,    1,0,0,            0,32'h3108,1,32'h3104,32'hAAAA3104,0);
    tv[15] = mk(0,1,32'h3300,    1,0,0,            1,32'h3200,0,0,0,0);
    tv[16] = mk(0,0,0,           0,0,0,            0,32'h3300,0,0,0,0);
    tv[17] = mk(0,0,0,           0,1,32'hDEAD0005, 0,32'h3300,0,0,0,0);
    tv[18] = mk(0,0,0,           1,0,0,            1,32'h3300,0,0,0,0);
    tv[19] = mk(0,1,32'h3400,    0,0,0,            0,32'h3304,0,0,0,0);
    tv[20] = mk(0,0,0,           0,1,32'hDEAD0006, 0,32'h3400,0,0,0,0);
    tv[21] = mk(0,0,0,           0,1,32'hDEAD0021, 1,32'h3400,0,0,0,0);
    tv[22] = mk(0,1,32'hFFFFFFFC,0,0,0,            1,32'h3400,0,0,0,0);
    tv[23] = mk(0,0,0,           1,0,0,            1,32'hFFFFFFFC,0,0,0,0);
    tv[24] = mk(0,0,0,           0,1,32'h0BADF00D, 0,32'h0,0,0,0,0);
    tv[25] = mk(0,0,0,           1,0,0,            1,32'h0,1,32'hFFFFFFFC,32'h0BADF00D,0);
    tv[26] = mk(0,0,0,           0,1,32'hAAAA0000, 0,32'h4,0,0,0,0);
    tv[27] = mk(0,0,0,           0,0,0,            1,32'h4,1,32'h0,32'hAAAA0000,0);
    tv[28] = mk(0,1,32'h3102,    0,0,0,            1,32'h4,0,0,0,0);
    tv[29] = mk(0,0,0,           0,0,0,            1,MIS,0,0,0,ALN);
    tv[30] = mk(0,0,0,           0,0,0,            1,MIS,0,0,0,0);

    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_pc", ipc, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_addr", addr, 32'h3000);
    chk("rst_exc", {31'd0, exc}, 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 31; i++) begin
      drive(tv[i].st, tv[i].rd, tv[i].rpc, tv[i].gnt, tv[i].rv, tv[i].rdata);
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, req}, {31'd0, tv[i].req});
      chk($sformatf("v%0d_addr", i), addr, tv[i].addr);
      chk($sformatf("v%0d_valid", i), {31'd0, valid}, {31'd0, tv[i].v});
      chk($sformatf("v%0d_exc", i), {31'd0, exc}, {31'd0, tv[i].exc});
      if (tv[i].v) begin
        chk($sformatf("v%0d_pc", i), ipc, tv[i].ipc);
        chk($sformatf("v%0d_instr", i), instr, tv[i].ins);
      end
      @(posedge clk);
      @(negedge clk);
    end

    // Fill the buffer, then hit reset mid-cycle.
    drive(0, 0, 0, 1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 32'h12345678);
    @(posedge clk);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("pre_rst_valid", {31'd0, valid}, 32'd1);
    chk("pre_rst_pc", ipc, MIS);
    chk("pre_rst_instr", instr, 32'h12345678);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_instr", instr, 32'd0);
    chk("arst_addr", addr, 32'h3000);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0);
    rstn = 1'b1;
    #1;
    chk("boot_req", {31'd0, req}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("first_req", {31'd0, req}, 32'd1);
    chk("first_addr", addr, 32'h3000);
    drive(0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
